// File: rtl/fetch_unit_if.sv
// Instruction-memory handshake between the fetch stage and instruction memory.
// The fetch side holds iREN/iaddr until ihit returns iload.
interface fetch_unit_if #(
   parameter int unsigned WORD_W = 32
);
   logic              iREN;
   logic [WORD_W-1:0] iaddr;
   logic              ihit;
   logic [WORD_W-1:0] iload;

   modport master (output iREN, iaddr, input ihit, iload);
   modport slave  (input iREN, iaddr, output ihit, iload);
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues held instruction-memory
// requests, and feeds IF/ID through a registered output plus a one-entry skid.
module fetch_unit #(
   parameter int unsigned             WORD_W  = 32,
   parameter logic [WORD_W-1:0]       PC_INIT = '0
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              halt,
   input  logic              stall_IF,
   input  logic              redirect,
   input  logic [WORD_W-1:0] redirect_pc,
   fetch_unit_if.master      imem,
   output logic [WORD_W-1:0] instruction,
   output logic [WORD_W-1:0] npc_IF,
   output logic              valid_IF
);

   typedef enum logic [1:0] {
      S_REQ    = 2'd0,
      S_HOLD   = 2'd1,
      S_DROP   = 2'd2,
      S_HALTED = 2'd3
   } state_t;

   localparam logic [WORD_W-1:0] FOUR = WORD_W'(4);

   state_t            state_q,      state_d;
   logic [WORD_W-1:0] pc_q,         pc_d;
   logic [WORD_W-1:0] target_q,     target_d;
   logic [WORD_W-1:0] instr_q,      instr_d;
   logic [WORD_W-1:0] npc_q,        npc_d;
   logic              valid_q,      valid_d;
   logic [WORD_W-1:0] skid_instr_q, skid_instr_d;
   logic [WORD_W-1:0] skid_npc_q,   skid_npc_d;
   logic              skid_vld_q,   skid_vld_d;

   logic [WORD_W-1:0] pc_plus4;
   logic [WORD_W-1:0] redir_aligned;

   assign pc_plus4      = pc_q + FOUR;
   assign redir_aligned = {redirect_pc[WORD_W-1:2], 2'b00};

   // The PC is only advanced on a completed fetch and is only loaded from the
   // redirect target once a squashed miss completes, so it always equals the
   // address currently being (or about to be) requested.
   assign imem.iREN   = (state_q == S_REQ) || (state_q == S_DROP);
   assign imem.iaddr  = pc_q;
   assign instruction = instr_q;
   assign npc_IF      = npc_q;
   assign valid_IF    = valid_q;

   // Next-state logic: halt > redirect > ihit/stall.
   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      target_d     = target_q;
      instr_d      = instr_q;
      npc_d        = npc_q;
      valid_d      = valid_q;
      skid_instr_d = skid_instr_q;
      skid_npc_d   = skid_npc_q;
      skid_vld_d   = skid_vld_q;

      if (halt) begin
         state_d    = S_HALTED;
         valid_d    = 1'b0;
         skid_vld_d = 1'b0;
      end else begin
         unique case (state_q)
            S_REQ: begin
               if (redirect) begin
                  valid_d    = 1'b0;
                  skid_vld_d = 1'b0;
                  if (imem.ihit) begin
                     pc_d    = redir_aligned;
                     state_d = S_REQ;
                  end else begin
                     target_d = redir_aligned;
                     state_d  = S_DROP;
                  end
               end else if (imem.ihit) begin
                  pc_d = pc_plus4;
                  if (!stall_IF) begin
                     instr_d = imem.iload;
                     npc_d   = pc_plus4;
                     valid_d = 1'b1;
                  end else begin
                     skid_instr_d = imem.iload;
                     skid_npc_d   = pc_plus4;
                     skid_vld_d   = 1'b1;
                     state_d      = S_HOLD;
                  end
               end else if (!stall_IF) begin
                  valid_d = 1'b0;
               end
            end
            S_HOLD: begin
               if (redirect) begin
                  pc_d       = redir_aligned;
                  valid_d    = 1'b0;
                  skid_vld_d = 1'b0;
                  state_d    = S_REQ;
               end else if (!stall_IF) begin
                  instr_d    = skid_instr_q;
                  npc_d      = skid_npc_q;
                  valid_d    = skid_vld_q;
                  skid_vld_d = 1'b0;
                  state_d    = S_REQ;
               end
            end
            S_DROP: begin
               valid_d = 1'b0;
               if (redirect) begin
                  target_d = redir_aligned;
               end
               // A redirect arriving with the completing response still wins.
               if (imem.ihit) begin
                  pc_d    = redirect ? redir_aligned : target_q;
                  state_d = S_REQ;
               end
            end
            S_HALTED: begin
               valid_d = 1'b0;
            end
            default: begin
               state_d = S_HALTED;
            end
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q      <= S_REQ;
         pc_q         <= PC_INIT;
         target_q     <= '0;
         instr_q      <= '0;
         npc_q        <= PC_INIT + FOUR;
         valid_q      <= 1'b0;
         skid_instr_q <= '0;
         skid_npc_q   <= '0;
         skid_vld_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         target_q     <= target_d;
         instr_q      <= instr_d;
         npc_q        <= npc_d;
         valid_q      <= valid_d;
         skid_instr_q <= skid_instr_d;
         skid_npc_q   <= skid_npc_d;
         skid_vld_q   <= skid_vld_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed testbench for fetch_unit: a simple memory model returns
// addr ^ 32'hA5A5_0000 whenever hit_en is set and a request is open.
module tb_fetch_unit;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic        halt = 1'b0;
   logic        stall_IF = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        hit_en = 1'b0;
   logic [31:0] instruction, npc_IF;
   logic        valid_IF;

   logic        rst_w = 1'b1;
   logic        hit_w = 1'b0;
   logic [31:0] instruction_w, npc_w;
   logic        valid_w;

   int n_vec = 0;
   int n_err = 0;
   int cnt40 = 0;

   always #5 CLK = ~CLK;

   fetch_unit_if #(.WORD_W(32)) imem ();
   fetch_unit_if #(.WORD_W(32)) imem_w ();

   assign imem.ihit    = hit_en & imem.iREN;
   assign imem.iload   = imem.iaddr ^ 32'hA5A5_0000;
   assign imem_w.ihit  = hit_w & imem_w.iREN;
   assign imem_w.iload = imem_w.iaddr ^ 32'hA5A5_0000;

   fetch_unit #(.WORD_W(32), .PC_INIT(32'h0000_0000)) dut (
      .CLK(CLK), .RST(RST), .halt(halt), .stall_IF(stall_IF),
      .redirect(redirect), .redirect_pc(redirect_pc), .imem(imem),
      .instruction(instruction), .npc_IF(npc_IF), .valid_IF(valid_IF)
   );

   fetch_unit #(.WORD_W(32), .PC_INIT(32'hFFFF_FFF8)) u_wrap (
      .CLK(CLK), .RST(rst_w), .halt(1'b0), .stall_IF(1'b0),
      .redirect(1'b0), .redirect_pc(32'h0), .imem(imem_w),
      .instruction(instruction_w), .npc_IF(npc_w), .valid_IF(valid_w)
   );

   // Counts every cycle in which address 0x40 is actually requested.
   always @(posedge CLK) begin
      if (imem.iREN && imem.iaddr == 32'h40) cnt40 <= cnt40 + 1;
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic do_reset();
      RST = 1'b1; halt = 1'b0; stall_IF = 1'b0; redirect = 1'b0; hit_en = 1'b0;
      tick();
      tick();
      RST = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++; if (valid_IF !== 1'b0) begin n_err++; $display("FAIL reset_valid got %b exp 0", valid_IF); end
      n_vec++; if (npc_IF !== 32'h4) begin n_err++; $display("FAIL reset_npc got %h exp 00000004", npc_IF); end
      n_vec++; if (instruction !== 32'h0) begin n_err++; $display("FAIL reset_instr got %h exp 00000000", instruction); end
      n_vec++; if (imem.iaddr !== 32'h0) begin n_err++; $display("FAIL reset_iaddr got %h exp 00000000", imem.iaddr); end
      n_vec++; if (imem.iREN !== 1'b1) begin n_err++; $display("FAIL reset_iren got %b exp 1", imem.iREN); end
   endtask

   task automatic test_stream();
      logic [31:0] pc;
      do_reset();
      hit_en = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         pc = 32'(k - 1) * 4;
         tick();
         n_vec++; if (valid_IF !== 1'b1) begin n_err++; $display("FAIL stream_valid k=%0d got %b exp 1", k, valid_IF); end
         n_vec++; if (npc_IF !== 32'(k) * 4) begin n_err++; $display("FAIL stream_npc k=%0d got %h exp %h", k, npc_IF, 32'(k) * 4); end
         n_vec++; if (instruction !== (pc ^ 32'hA5A5_0000)) begin n_err++; $display("FAIL stream_instr k=%0d got %h exp %h", k, instruction, pc ^ 32'hA5A5_0000); end
      end
   endtask

   task automatic test_stall();
      do_reset();
      hit_en = 1'b1;
      tick();
      tick();
      stall_IF = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_vec++; if (instruction !== 32'hA5A5_0004) begin n_err++; $display("FAIL stall_instr c=%0d got %h exp a5a50004", c, instruction); end
         n_vec++; if (npc_IF !== 32'h8) begin n_err++; $display("FAIL stall_npc c=%0d got %h exp 00000008", c, npc_IF); end
         n_vec++; if (imem.iREN !== 1'b0) begin n_err++; $display("FAIL stall_iren c=%0d got %b exp 0", c, imem.iREN); end
      end
      stall_IF = 1'b0;
      tick();
      n_vec++; if (instruction !== 32'hA5A5_0008) begin n_err++; $display("FAIL release_instr got %h exp a5a50008", instruction); end
      n_vec++; if (npc_IF !== 32'hC) begin n_err++; $display("FAIL release_npc got %h exp 0000000c", npc_IF); end
      n_vec++; if (valid_IF !== 1'b1) begin n_err++; $display("FAIL release_valid got %b exp 1", valid_IF); end
      n_vec++; if (imem.iaddr !== 32'hC || imem.iREN !== 1'b1) begin n_err++; $display("FAIL release_req got %h/%b exp 0000000c/1", imem.iaddr, imem.iREN); end
      tick();
      n_vec++; if (instruction !== 32'hA5A5_000C || npc_IF !== 32'h10) begin n_err++; $display("FAIL resume got %h/%h exp a5a5000c/00000010", instruction, npc_IF); end
   endtask

   task automatic test_redirect_miss();
      do_reset();
      hit_en = 1'b1;
      for (int c = 0; c < 8; c++) tick();
      n_vec++; if (imem.iaddr !== 32'h20) begin n_err++; $display("FAIL drop_pre_iaddr got %h exp 00000020", imem.iaddr); end
      hit_en = 1'b0;
      redirect = 1'b1;
      redirect_pc = 32'h0000_0103;
      tick();
      redirect = 1'b0;
      n_vec++; if (valid_IF !== 1'b0) begin n_err++; $display("FAIL drop_valid got %b exp 0", valid_IF); end
      for (int c = 0; c < 3; c++) begin
         n_vec++; if (imem.iaddr !== 32'h20 || imem.iREN !== 1'b1) begin n_err++; $display("FAIL drop_hold c=%0d got %h/%b exp 00000020/1", c, imem.iaddr, imem.iREN); end
         if (c < 2) tick();
      end
      hit_en = 1'b1;
      tick();
      n_vec++; if (imem.iaddr !== 32'h100) begin n_err++; $display("FAIL drop_next_iaddr got %h exp 00000100", imem.iaddr); end
      n_vec++; if (valid_IF !== 1'b0) begin n_err++; $display("FAIL drop_discard_valid got %b exp 0", valid_IF); end
      tick();
      n_vec++; if (instruction !== 32'hA5A5_0100 || npc_IF !== 32'h104 || valid_IF !== 1'b1) begin n_err++; $display("FAIL drop_refetch got %h/%h/%b exp a5a50100/00000104/1", instruction, npc_IF, valid_IF); end
   endtask

   task automatic test_double_redirect();
      int c40;
      do_reset();
      c40 = cnt40;
      redirect = 1'b1;
      redirect_pc = 32'h40;
      tick();
      redirect_pc = 32'h80;
      tick();
      redirect = 1'b0;
      n_vec++; if (imem.iaddr !== 32'h0 || imem.iREN !== 1'b1) begin n_err++; $display("FAIL dbl_hold got %h/%b exp 00000000/1", imem.iaddr, imem.iREN); end
      hit_en = 1'b1;
      tick();
      n_vec++; if (imem.iaddr !== 32'h80) begin n_err++; $display("FAIL dbl_iaddr got %h exp 00000080", imem.iaddr); end
      tick();
      n_vec++; if (instruction !== 32'hA5A5_0080 || npc_IF !== 32'h84) begin n_err++; $display("FAIL dbl_instr got %h/%h exp a5a50080/00000084", instruction, npc_IF); end
      n_vec++; if (cnt40 !== c40) begin n_err++; $display("FAIL dbl_no40 got %0d exp %0d", cnt40, c40); end
   endtask

   task automatic test_redirect_hit();
      do_reset();
      hit_en = 1'b1;
      tick();
      redirect = 1'b1;
      redirect_pc = 32'h0000_0203;
      tick();
      redirect = 1'b0;
      n_vec++; if (imem.iaddr !== 32'h200 || valid_IF !== 1'b0) begin n_err++; $display("FAIL rhit_flush got %h/%b exp 00000200/0", imem.iaddr, valid_IF); end
      tick();
      n_vec++; if (instruction !== 32'hA5A5_0200 || npc_IF !== 32'h204 || valid_IF !== 1'b1) begin n_err++; $display("FAIL rhit_refetch got %h/%h/%b exp a5a50200/00000204/1", instruction, npc_IF, valid_IF); end
   endtask

   task automatic test_halt();
      do_reset();
      hit_en = 1'b1;
      tick();
      stall_IF = 1'b1;
      tick();
      n_vec++; if (imem.iREN !== 1'b0 || imem.iaddr !== 32'h8) begin n_err++; $display("FAIL halt_pre got %b/%h exp 0/00000008", imem.iREN, imem.iaddr); end
      halt = 1'b1;
      tick();
      halt = 1'b0;
      stall_IF = 1'b0;
      n_vec++; if (valid_IF !== 1'b0) begin n_err++; $display("FAIL halt_valid got %b exp 0", valid_IF); end
      for (int c = 0; c < 3; c++) begin
         tick();
         n_vec++; if (imem.iREN !== 1'b0 || valid_IF !== 1'b0) begin n_err++; $display("FAIL halted c=%0d got %b/%b exp 0/0", c, imem.iREN, valid_IF); end
      end
      RST = 1'b1;
      tick();
      RST = 1'b0;
      n_vec++; if (imem.iaddr !== 32'h0 || imem.iREN !== 1'b1) begin n_err++; $display("FAIL halt_reset got %h/%b exp 00000000/1", imem.iaddr, imem.iREN); end
   endtask

   task automatic test_wrap();
      rst_w = 1'b1;
      tick();
      rst_w = 1'b0;
      n_vec++; if (imem_w.iaddr !== 32'hFFFF_FFF8 || npc_w !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_reset got %h/%h exp fffffff8/fffffffc", imem_w.iaddr, npc_w); end
      hit_w = 1'b1;
      tick();
      n_vec++; if (imem_w.iaddr !== 32'hFFFF_FFFC || npc_w !== 32'hFFFF_FFFC || instruction_w !== 32'h5A5A_FFF8) begin n_err++; $display("FAIL wrap_1 got %h/%h/%h exp fffffffc/fffffffc/5a5afff8", imem_w.iaddr, npc_w, instruction_w); end
      tick();
      n_vec++; if (imem_w.iaddr !== 32'h0 || npc_w !== 32'h0 || instruction_w !== 32'h5A5A_FFFC) begin n_err++; $display("FAIL wrap_2 got %h/%h/%h exp 00000000/00000000/5a5afffc", imem_w.iaddr, npc_w, instruction_w); end
      tick();
      n_vec++; if (imem_w.iaddr !== 32'h4 || npc_w !== 32'h4 || instruction_w !== 32'hA5A5_0000 || valid_w !== 1'b1) begin n_err++; $display("FAIL wrap_3 got %h/%h/%h/%b exp 00000004/00000004/a5a50000/1", imem_w.iaddr, npc_w, instruction_w, valid_w); end
      hit_w = 1'b0;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_stall();
      test_redirect_miss();
      test_double_redirect();
      test_redirect_hit();
      test_halt();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
